// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the fixed-point square-root unit and its companion
// squarer (sqrt_inverse_square).
//   state_t  : three-state control sequence used by both blocks
//   Q_WIDTH  : default operand/result width (Q8.8 -> 16 bits)
//   Q_FRAC   : default number of fractional bits (Q8.8 -> 8 bits)
// -----------------------------------------------------------------------------
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROCESSING = 2'd1,
    DONE       = 2'd2
  } state_t;

  localparam int Q_WIDTH = 16;
  localparam int Q_FRAC  = 8;

endpackage

// File: rtl/sqrt_inverse_square.sv
// -----------------------------------------------------------------------------
// sqrt_inverse_square
// Sequential unsigned fixed-point squarer: y_sq = (y*y) >> FRAC_BITS, built
// from one shift-add partial product per clock (WIDTH cycles), then a
// truncate/saturate step. Used beside the square-root unit to check a root
// against its operand.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous, active-low reset
//   valid_in  in   1      start request, only honoured in IDLE
//   y         in   WIDTH  unsigned fixed-point operand, captured with valid_in
//   y_sq      out  WIDTH  truncated/saturated square, held until next result
//   ovf       out  1      result saturated; held alongside y_sq
//   valid_out out  1      one-cycle pulse marking a new y_sq/ovf
//   busy      out  1      high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module sqrt_inverse_square
  import sqrt_pkg::*;
#(
  parameter int WIDTH     = Q_WIDTH,
  parameter int FRAC_BITS = Q_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_sq,
  output logic             ovf,
  output logic             valid_out,
  output logic             busy
);

  localparam int         ACC_W     = 2 * WIDTH;
  localparam int         OVF_LSB   = WIDTH + FRAC_BITS;
  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mult;
  logic [4:0]         r_iter;
  logic [WIDTH-1:0]   r_y_sq;
  logic               r_ovf;
  logic               r_valid_out;
  logic [WIDTH:0]     w_sat;

  // Drop FRAC_BITS of fraction (truncation toward zero); any product bit at or
  // above 2^(WIDTH+FRAC_BITS) cannot be represented, so clamp to all ones.
  // Returned as {ovf, value}.
  function automatic logic [WIDTH:0] sat_trunc(input logic [ACC_W-1:0] acc);
    logic hi;
    hi = |acc[ACC_W-1:OVF_LSB];
    if (hi) sat_trunc = {1'b1, {WIDTH{1'b1}}};
    else    sat_trunc = {1'b0, acc[OVF_LSB-1:FRAC_BITS]};
  endfunction

  assign w_sat = sat_trunc(r_acc);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       if (valid_in) w_state_next = PROCESSING;
      PROCESSING: if (r_iter == LAST_ITER) w_state_next = DONE;
      DONE:       w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mult      <= '0;
      r_iter      <= '0;
      r_y_sq      <= '0;
      r_ovf       <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_valid_out <= 1'b0;
      case (r_state)
        // Capture: operand becomes both multiplicand and multiplier
        IDLE: begin
          if (valid_in) begin
            r_mcand <= {{WIDTH{1'b0}}, y};
            r_mult  <= y;
            r_acc   <= '0;
            r_iter  <= '0;
          end
        end
        // Shift-add: one multiplier bit per cycle, always WIDTH cycles
        PROCESSING: begin
          if (r_mult[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_iter  <= r_iter + 5'd1;
        end
        // Result: truncate/saturate and publish
        DONE: begin
          r_y_sq      <= w_sat[WIDTH-1:0];
          r_ovf       <= w_sat[WIDTH];
          r_valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign y_sq      = r_y_sq;
  assign ovf       = r_ovf;
  assign valid_out = r_valid_out;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sqrt_inverse_square.sv
module tb_sqrt_inverse_square;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] y;
  logic [15:0] y_sq;
  logic        ovf;
  logic        valid_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sqrt_inverse_square #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .y         (y),
    .y_sq      (y_sq),
    .ovf       (ovf),
    .valid_out (valid_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request; returns at the falling edge just after the capture edge.
  task automatic start_op(input logic [15:0] v);
    @(negedge clk);
    valid_in = 1'b1;
    y        = v;
    @(negedge clk);
    valid_in = 1'b0;
    y        = 16'hDEAD;
  endtask

  // Measures edges from capture to valid_out and cycles with busy high.
  // lat stays -1 if no result appears within the budget.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (valid_out) begin
        lat = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    y        = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({y_sq, ovf, valid_out, busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: y_sq=%h ovf=%b vo=%b busy=%b, required all 0",
               y_sq, ovf, valid_out, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    start_op(16'h0200);
    wait_done(lat, bc);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required 17", lat);
    end
    checks++;
    if (bc !== 17) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required 17", bc);
    end
    checks++;
    if (y_sq !== 16'h0400 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_2p0: y_sq=%h ovf=%b, required 0400/0", y_sq, ovf);
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || y_sq !== 16'h0400) begin
      errors++;
      $display("FAIL basic_pulse_hold: vo=%b y_sq=%h, required 0/0400", valid_out, y_sq);
    end
  endtask

  task automatic test_values();
    logic [15:0] vin  [7] = '{16'h0180, 16'h0001, 16'h0000, 16'h0FFF, 16'h1000, 16'hFFFF, 16'h0400};
    logic [15:0] vexp [7] = '{16'h0240, 16'h0000, 16'h0000, 16'hFFE0, 16'hFFFF, 16'hFFFF, 16'h1000};
    logic        oexp [7] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      start_op(vin[i]);
      wait_done(lat, bc);
      checks++;
      if (lat !== 17) begin
        errors++;
        $display("FAIL value_latency y=%h: got %0d, required 17", vin[i], lat);
      end
      checks++;
      if (y_sq !== vexp[i] || ovf !== oexp[i]) begin
        errors++;
        $display("FAIL value y=%h: y_sq=%h ovf=%b, required %h/%b",
                 vin[i], y_sq, ovf, vexp[i], oexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first_c = -1;
    int last_c = -1;
    int bad_gap = 0;
    int bad_val = 0;
    @(negedge clk);
    valid_in = 1'b1;
    y        = 16'h0300;
    for (int c = -1; c <= 60; c++) begin
      @(negedge clk);
      if (c + 1 == 5) y = 16'h0500;
      if (c + 1 == 6) y = 16'h0300;
      if (c + 1 == 53) valid_in = 1'b0;
      if (valid_out) begin
        pulses++;
        if (first_c < 0) first_c = c + 1;
        else if ((c + 1) - last_c != 18) bad_gap++;
        last_c = c + 1;
        if (y_sq !== 16'h0900 || ovf !== 1'b0) bad_val++;
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d, required 3", pulses);
    end
    checks++;
    if (first_c !== 17) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d, required 17", first_c);
    end
    checks++;
    if (bad_gap !== 0) begin
      errors++;
      $display("FAIL b2b_interval: %0d gaps not 18, required 0", bad_gap);
    end
    checks++;
    if (bad_val !== 0) begin
      errors++;
      $display("FAIL b2b_values: %0d results not 0900, required 0", bad_val);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    int stray = 0;
    start_op(16'h0400);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({y_sq, ovf, valid_out, busy} !== 19'd0) begin
      errors++;
      $display("FAIL abort_outputs: y_sq=%h ovf=%b vo=%b busy=%b, required all 0",
               y_sq, ovf, valid_out, busy);
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_out || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL abort_no_result: %0d active cycles, required 0", stray);
    end
    start_op(16'h0200);
    wait_done(lat, bc);
    checks++;
    if (lat !== 17 || y_sq !== 16'h0400 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: lat=%0d y_sq=%h ovf=%b, required 17/0400/0", lat, y_sq, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
